// File: rtl/rfphoenix_fifo_reader.sv
// rfphoenix_fifo_reader: read-side controller for a 64-entry rfPhoenix FIFO.
// Pops entries as soon as there is room for them and re-presents them on a
// valid/ready stream through a small circular skid buffer.
module rfphoenix_fifo_reader #(
    parameter int WID   = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_wr,
    input  logic                     fifo_v,
    input  logic [5:0]               fifo_cnt,
    input  logic [WID-1:0]           fifo_dout,
    output logic                     fifo_rd,
    output logic                     out_v,
    output logic [WID-1:0]           out_dat,
    input  logic                     out_rdy,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   out_cnt,
    output logic [5:0]               fifo_lvl
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW:0]   OCC_MAX = (CW + 1)'(DEPTH);

    // The controller state is fully implied by (inflight, out_cnt); the enum
    // only names it so the issue rule reads naturally.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_HOLD,
        ST_FULL
    } rd_state_t;

    logic             inflight;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [WID-1:0]   mem [DEPTH];
    logic [CW:0]      occ;
    rd_state_t        state;
    logic             capture;
    logic             consume;

    // Decode the occupancy-derived state and the pop/capture/consume strobes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state   = ST_EMPTY;
        occ     = {1'b0, out_cnt} + (CW + 1)'(inflight);
        if (occ >= OCC_MAX) begin
            state = ST_FULL;
        end else if (inflight) begin
            state = ST_FILLING;
        end else if (out_cnt != '0) begin
            state = ST_HOLD;
        end

        // A read that coincides with a write is not a pop in the FIFO, so
        // never issue one then; a full local buffer (including the entry in
        // flight) also blocks issue.
        fifo_rd = fifo_v & ~fifo_wr & ~flush & ~rst & (state != ST_FULL);

        out_v   = (out_cnt != '0);
        out_dat = mem[head];
        capture = inflight & ~flush;
        consume = out_v & out_rdy & ~flush;
    end

    // Pointer, occupancy, in-flight and level registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            out_cnt  <= '0;
            fifo_lvl <= '0;
        end else begin
            fifo_lvl <= fifo_cnt;
            inflight <= fifo_rd;
            if (flush) begin
                head    <= '0;
                tail    <= '0;
                out_cnt <= '0;
            end else begin
                if (capture) begin
                    tail <= tail + PTR_ONE;
                end
                if (consume) begin
                    head <= head + PTR_ONE;
                end
                case ({capture, consume})
                    2'b10:   out_cnt <= out_cnt + CNT_ONE;
                    2'b01:   out_cnt <= out_cnt - CNT_ONE;
                    default: out_cnt <= out_cnt;
                endcase
            end
        end
    end

    // Local buffer storage: written at the tail when a popped entry arrives.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is cleared on reset because out_dat is visible
        // straight from mem[head] and must read as zero after reset.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (capture) begin
            mem[tail] <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_rfphoenix_fifo_reader.sv
// tb_rfphoenix_fifo_reader: self-checking bench with a behavioural FIFO model
// and an in-order scoreboard of written entries.
module tb_rfphoenix_fifo_reader;

    localparam int WID   = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           fifo_wr = 1'b0;
    logic [WID-1:0] wr_data = '0;
    logic           out_rdy = 1'b0;
    logic           flush = 1'b0;

    logic           fifo_v = 1'b0;
    logic [5:0]     fifo_cnt = '0;
    logic [WID-1:0] fifo_dout = '0;

    logic           fifo_rd;
    logic           out_v;
    logic [WID-1:0] out_dat;
    logic [CW-1:0]  out_cnt;
    logic [5:0]     fifo_lvl;

    int errors = 0;
    int checks = 0;

    logic [WID-1:0] fq[$];
    logic [WID-1:0] exp_q[$];
    int             popped = 0;
    int             consumed = 0;
    logic           tb_inflight = 1'b0;
    logic           underflow_seen = 1'b0;

    always #5 clk = ~clk;

    rfphoenix_fifo_reader #(.WID(WID), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_wr   (fifo_wr),
        .fifo_v    (fifo_v),
        .fifo_cnt  (fifo_cnt),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .out_v     (out_v),
        .out_dat   (out_dat),
        .out_rdy   (out_rdy),
        .flush     (flush),
        .out_cnt   (out_cnt),
        .fifo_lvl  (fifo_lvl)
    );

    // Behavioural 64-entry FIFO: registered head data, combinational-looking
    // v/cnt that already reflect a pop in the following cycle.
    always @(posedge clk) begin
        if (fifo_rd && !fifo_wr) begin
            if (fq.size() == 0) begin
                underflow_seen <= 1'b1;
            end else begin
                fifo_dout <= fq.pop_front();
                popped++;
            end
        end
        if (fifo_wr) fq.push_back(wr_data);
        fifo_v      <= (fq.size() != 0);
        fifo_cnt    <= 6'(fq.size());
        tb_inflight <= fifo_rd;
    end

    // Per-cycle protocol checks and scoreboard update, sampled mid-cycle.
    task automatic observe();
        logic [WID-1:0] e;
        checks++;
        if (fifo_rd && fifo_wr) begin
            errors++;
            $display("FAIL rd_with_wr: fifo_rd=%0b while fifo_wr=1, required 0 (t=%0t)", fifo_rd, $time);
        end
        checks++;
        if (underflow_seen) begin
            errors++;
            $display("FAIL underflow: pop of empty FIFO seen=%0b, required 0 (t=%0t)", underflow_seen, $time);
            underflow_seen = 1'b0;
        end
        checks++;
        if (out_cnt > CW'(DEPTH)) begin
            errors++;
            $display("FAIL out_cnt_range: out_cnt=%0d, required <= %0d (t=%0t)", out_cnt, DEPTH, $time);
        end
        if (tb_inflight && !flush && !rst) begin
            checks++;
            if (out_cnt == CW'(DEPTH)) begin
                errors++;
                $display("FAIL capture_full: capture with out_cnt=%0d, required < %0d (t=%0t)", out_cnt, DEPTH, $time);
            end
        end
        if (rst || flush) begin
            while (consumed < popped && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                consumed++;
            end
        end else if (out_v && out_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: out_dat=%0d with no expected entry (t=%0t)", out_dat, $time);
            end else begin
                e = exp_q.pop_front();
                if (out_dat !== e) begin
                    errors++;
                    $display("FAIL sb_order: out_dat=%0d, required %0d (t=%0t)", out_dat, e, $time);
                end
            end
            consumed++;
        end
    endtask

    // One clock of stimulus: inputs change just after the edge, outputs are
    // observed at the falling edge of the same cycle.
    task automatic drive(input logic wr_i, input logic [WID-1:0] d, input logic rdy_i,
                         input logic fl_i, input logic rst_i);
        @(posedge clk);
        #1;
        fifo_wr = wr_i;
        wr_data = d;
        out_rdy = rdy_i;
        flush   = fl_i;
        rst     = rst_i;
        if (wr_i) exp_q.push_back(d);
        @(negedge clk);
        observe();
    endtask

    task automatic load(input int n, input int base, input logic rdy_i);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, WID'(base + i), rdy_i, 1'b0, 1'b0);
            checks++;
            if (fifo_rd !== 1'b0) begin
                errors++;
                $display("FAIL load_rd: fifo_rd=%0b during write, required 0", fifo_rd);
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: fifo_rd=%0b, required 0", fifo_rd); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v: out_v=%0b, required 0", out_v); end
        checks++;
        if (out_dat !== '0) begin errors++; $display("FAIL reset_out_dat: out_dat=%0d, required 0", out_dat); end
        checks++;
        if (out_cnt !== '0) begin errors++; $display("FAIL reset_out_cnt: out_cnt=%0d, required 0", out_cnt); end
        checks++;
        if (fifo_lvl !== '0) begin errors++; $display("FAIL reset_fifo_lvl: fifo_lvl=%0d, required 0", fifo_lvl); end
    endtask

    task automatic test_stream();
        logic           exp_r [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic           exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [WID-1:0] exp_d [6] = '{3'd0, 3'd0, 3'd5, 3'd6, 3'd7, 3'd0};
        load(3, 5, 1'b1);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (fifo_rd !== exp_r[c]) begin
                errors++;
                $display("FAIL stream_rd[%0d]: fifo_rd=%0b, required %0b", c, fifo_rd, exp_r[c]);
            end
            checks++;
            if (out_v !== exp_v[c]) begin
                errors++;
                $display("FAIL stream_v[%0d]: out_v=%0b, required %0b", c, out_v, exp_v[c]);
            end
            if (exp_v[c]) begin
                checks++;
                if (out_dat !== exp_d[c]) begin
                    errors++;
                    $display("FAIL stream_dat[%0d]: out_dat=%0d, required %0d", c, out_dat, exp_d[c]);
                end
            end
            if (c == 1) begin
                checks++;
                if (fifo_lvl !== 6'd3) begin
                    errors++;
                    $display("FAIL stream_lvl: fifo_lvl=%0d, required 3", fifo_lvl);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        int got = 0;
        load(10, 0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
            pops += int'(fifo_rd);
        end
        checks++;
        if (pops != DEPTH) begin errors++; $display("FAIL bp_pops: pops=%0d, required %0d", pops, DEPTH); end
        checks++;
        if (fifo_rd !== 1'b0) begin errors++; $display("FAIL bp_rd: fifo_rd=%0b, required 0", fifo_rd); end
        checks++;
        if (out_cnt !== CW'(DEPTH)) begin errors++; $display("FAIL bp_cnt: out_cnt=%0d, required %0d", out_cnt, DEPTH); end
        checks++;
        if (fifo_cnt !== 6'd6) begin errors++; $display("FAIL bp_fifo_cnt: fifo_cnt=%0d, required 6", fifo_cnt); end
        for (int c = 0; c < 30; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (out_v) got++;
        end
        checks++;
        if (got != 10) begin errors++; $display("FAIL bp_drain: drained=%0d, required 10", got); end
        checks++;
        if (out_v !== 1'b0) begin errors++; $display("FAIL bp_empty: out_v=%0b, required 0", out_v); end
    endtask

    task automatic test_wr_collision();
        logic [WID-1:0] got[$];
        logic [WID-1:0] want [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        load(3, 1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (fifo_rd !== 1'b1) begin errors++; $display("FAIL wr_first_pop: fifo_rd=%0b, required 1", fifo_rd); end
        if (out_v) got.push_back(out_dat);
        drive(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        checks++;
        if (fifo_rd !== 1'b0) begin errors++; $display("FAIL wr_suppress: fifo_rd=%0b, required 0", fifo_rd); end
        if (out_v) got.push_back(out_dat);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (out_v) got.push_back(out_dat);
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL wr_count: entries=%0d, required 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("FAIL wr_order[%0d]: out_dat=%0d, required %0d", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [WID-1:0] got[$];
        load(3, 3, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (fifo_rd !== 1'b1) begin errors++; $display("FAIL flush_pop: fifo_rd=%0b, required 1", fifo_rd); end
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (fifo_rd !== 1'b0) begin errors++; $display("FAIL flush_rd: fifo_rd=%0b, required 0", fifo_rd); end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_cnt !== '0) begin errors++; $display("FAIL flush_cnt: out_cnt=%0d, required 0", out_cnt); end
        checks++;
        if (out_v !== 1'b0) begin errors++; $display("FAIL flush_v: out_v=%0b, required 0", out_v); end
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (out_v) got.push_back(out_dat);
        end
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL flush_count: entries=%0d, required 2", got.size());
        end else begin
            checks++;
            if (got[0] !== 3'd4 || got[1] !== 3'd5) begin
                errors++;
                $display("FAIL flush_resume: got %0d,%0d, required 4,5", got[0], got[1]);
            end
        end
    endtask

    task automatic test_random();
        int n_wr = 0;
        int n_out = 0;
        logic wr;
        for (int c = 0; c < 100; c++) begin
            wr = ($urandom_range(0, 9) < 4) && (fq.size() < 60);
            drive(wr, WID'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (wr) n_wr++;
            if (out_v && out_rdy) n_out++;
        end
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (out_v) n_out++;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: pending=%0d, required 0", exp_q.size()); end
        checks++;
        if (n_out != n_wr) begin errors++; $display("FAIL rand_count: outputs=%0d, required %0d", n_out, n_wr); end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        load(6, 2, 1'b0);
        for (int c = 0; c < 20 && !found; c++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
            if (out_cnt == CW'(2)) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rmid_fill: out_cnt never reached 2, required within 20 cycles"); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (fifo_rd !== 1'b0) begin errors++; $display("FAIL rmid_rd: fifo_rd=%0b, required 0", fifo_rd); end
        checks++;
        if (out_cnt !== CW'(3)) begin errors++; $display("FAIL rmid_pre_cnt: out_cnt=%0d, required 3", out_cnt); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_v !== 1'b0) begin errors++; $display("FAIL rmid_v: out_v=%0b, required 0", out_v); end
        checks++;
        if (out_dat !== '0) begin errors++; $display("FAIL rmid_dat: out_dat=%0d, required 0", out_dat); end
        checks++;
        if (out_cnt !== '0) begin errors++; $display("FAIL rmid_cnt: out_cnt=%0d, required 0", out_cnt); end
        checks++;
        if (fifo_lvl !== '0) begin errors++; $display("FAIL rmid_lvl: fifo_lvl=%0d, required 0", fifo_lvl); end
        for (int c = 0; c < 15; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_drain: pending=%0d, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wr_collision();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
